// File: rtl/btn_pkg.sv
// Shared definitions for the button event generator: FSM state encodings and
// timing constants for silicon and for simulation.
package btn_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PRESSED = ST_PRESSED,
        LONG    = ST_LONG
    } btn_state_t;

    localparam int LONG_CYCLES_DEF   = 12_500_000;
    localparam int REPEAT_CYCLES_DEF = 2_500_000;

    localparam int LONG_CYCLES_SIM   = 8;
    localparam int REPEAT_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_edge.sv
// Polarity normalisation and edge detection of the debounced button level.
// rise/fall are combinational against the registered level lvl_q.
module btn_edge
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic lvl;
    logic lvl_q;

    assign lvl = in ^ ACTIVE_LOW;

    // lvl_q clears to released so an idle-level input never looks like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/btn_evt.sv
// Button event generator: turns a debounced level into registered single-cycle
// press/release/click/long-press/repeat pulses plus a registered held level.
module btn_evt
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic held,
    output logic press,
    // release and repeat are reserved words, hence the _evt suffix
    output logic release_evt,
    output logic click,
    output logic long_press,
    output logic repeat_evt
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);

    logic rise;
    logic fall;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic held_d;
    logic press_d;
    logic release_d;
    logic click_d;
    logic long_d;
    logic repeat_d;

    btn_edge #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .rise (rise),
        .fall (fall)
    );

    // Release is tested first in every held state so it beats a threshold hit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end

            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register stage: every event appears one edge after detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            held        <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            held        <= held_d;
            press       <= press_d;
            release_evt <= release_d;
            click       <= click_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
        end
    end

endmodule

// File: tb/tb_btn_evt.sv
// Scoreboard bench for btn_evt: one instance with auto-repeat, one with repeat
// disabled, both driven by the same debounced level.
module tb_btn_evt;
    import btn_pkg::*;

    localparam int L = LONG_CYCLES_SIM;
    localparam int R = REPEAT_CYCLES_SIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b1;

    logic held_a, press_a, release_a, click_a, long_a, repeat_a;
    logic held_b, press_b, release_b, click_b, long_b, repeat_b;

    btn_evt #(
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (8),
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .held        (held_a),
        .press       (press_a),
        .release_evt (release_a),
        .click       (click_a),
        .long_press  (long_a),
        .repeat_evt  (repeat_a)
    );

    btn_evt #(
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (8),
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .held        (held_b),
        .press       (press_b),
        .release_evt (release_b),
        .click       (click_b),
        .long_press  (long_b),
        .repeat_evt  (repeat_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_pressed[2];
    int   m_j[2];
    int   long_cnt_b;
    int   repeat_cnt_b;
    int   release_cnt_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour in terms of edges elapsed since the press edge.
    // Vector order: {held, press, release, click, long_press, repeat}.
    function automatic logic [5:0] model_step(input int idx, input int rep,
                                              input logic r, input logic lvl);
        logic [5:0] v;
        v = '0;
        if (r) begin
            m_pressed[idx] = 0;
            m_j[idx]       = 0;
        end else if (m_pressed[idx] == 0) begin
            if (lvl) begin
                m_pressed[idx] = 1;
                m_j[idx]       = 0;
                v[4]           = 1'b1;
            end
        end else if (!lvl) begin
            m_pressed[idx] = 0;
            v[3]           = 1'b1;
            v[2]           = ((m_j[idx] + 1) <= L);
        end else begin
            m_j[idx] = m_j[idx] + 1;
            v[1]     = (m_j[idx] == L);
            v[0]     = (rep != 0) && (m_j[idx] > L) && (((m_j[idx] - L) % rep) == 0);
        end
        v[5] = (m_pressed[idx] != 0);
        return v;
    endfunction

    task automatic step(input logic r, input logic in_v);
        exp_t e;
        @(negedge clk);
        rst = r;
        in  = in_v;
        e.a = model_step(0, R, r, ~in_v);
        e.b = model_step(1, 0, r, ~in_v);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check_eq($sformatf("sb_empty@%0d", cyc), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("dut_a@%0d", cyc),
                     {26'd0, held_a, press_a, release_a, click_a, long_a, repeat_a}, {26'd0, e.a});
            check_eq($sformatf("dut_b@%0d", cyc),
                     {26'd0, held_b, press_b, release_b, click_b, long_b, repeat_b}, {26'd0, e.b});
        end
        long_cnt_b    += int'(long_b);
        repeat_cnt_b  += int'(repeat_b);
        release_cnt_b += int'(release_b);
    endtask

    task automatic hold_seq(input int n_hold, input int n_idle);
        for (int i = 0; i < n_hold; i++) step(1'b0, 1'b0);
        for (int i = 0; i < n_idle; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        m_pressed = '{0, 0};
        m_j       = '{0, 0};

        // reset, then idle level: nothing may fire
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        // short click, minimum press, long press with repeats
        hold_seq(3, 4);
        hold_seq(1, 3);
        hold_seq(22, 4);

        // release exactly on the long edge, then exactly on the first repeat edge
        hold_seq(8, 4);
        hold_seq(12, 4);

        // reset while held, button still down when reset drops
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // long hold: event counts on the repeat-disabled instance
        long_cnt_b    = 0;
        repeat_cnt_b  = 0;
        release_cnt_b = 0;
        hold_seq(40, 4);
        check_eq("b_long_count", long_cnt_b, 1);
        check_eq("b_repeat_count", repeat_cnt_b, 0);
        check_eq("b_release_count", release_cnt_b, 1);

        check_eq("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
